// File: rtl/ber_pkg.sv
// Shared constants and types for the ber_channel_mc bit-error injector.
package ber_pkg;

    typedef logic [31:0] prob_t;

    // Galois LFSR taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;
    localparam logic [31:0] LANE_SEED_MULT = 32'h9E37_79B9;

    typedef enum logic {
        ST_GOOD  = 1'b0,
        ST_BURST = 1'b1
    } lane_st_t;

    // Per-lane decorrelated seed; the all-zero LFSR lock-up state is never loaded.
    function automatic logic [31:0] lane_seed(input logic [31:0] base, input logic [31:0] lane);
        logic [31:0] v;
        v = base ^ (lane * LANE_SEED_MULT);
        if (v == 32'h0) begin
            v = 32'h1;
        end
        return v;
    endfunction

endpackage

// File: rtl/ber_lfsr32.sv
// One 32-bit Galois LFSR with synchronous reset, parallel load and advance.
module ber_lfsr32
    import ber_pkg::*;
#(
    parameter logic [31:0] RST_VAL = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    input  logic        i_adv,
    output logic [31:0] o_state
);

    logic [31:0] r_state;
    logic [31:0] w_next;

    assign w_next = {1'b0, r_state[31:1]} ^ (r_state[0] ? LFSR_POLY : 32'h0);

    // Load has priority so a seed_load beat never advances the sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RST_VAL;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/ber_channel_mc.sv
// Multi-lane reproducible bit-error injector with per-lane LFSR draws and a saturating error counter.
// Optional burst-error mode is built only when BER_INJ_BURST_EN is defined.
module ber_channel_mc
    import ber_pkg::*;
#(
    parameter int          LANES        = 4,
    parameter int          DW           = 16,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] DEFAULT_SEED = 32'hACE1_2468
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en,
    input  logic [31:0]           cfg_thresh,
    input  logic [31:0]           cfg_burst_thresh,
    input  logic [7:0]            cfg_burst_len,
    input  logic [LANES-1:0]      lane_mask,
    input  logic                  seed_load,
    input  logic [31:0]           seed,
    input  logic                  cnt_clr,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   in_data,
    output logic                  out_valid,
    output logic [LANES*DW-1:0]   out_data,
    output logic [LANES-1:0]      err_flag,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int BW = $clog2(DW);

    logic [31:0]           w_lfsr [LANES];
    prob_t                 w_thr  [LANES];
    logic [LANES-1:0]      w_hit;
    logic [LANES*DW-1:0]   w_flip;
    logic [CNT_W:0]        w_pop;
    logic [CNT_W:0]        w_sum;

    logic                  r_valid;
    logic [LANES*DW-1:0]   r_data;
    logic [LANES-1:0]      r_flag;
    logic [CNT_W-1:0]      r_cnt;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ber_lfsr32 #(
            .RST_VAL (lane_seed(DEFAULT_SEED, 32'(i)))
        ) u_lfsr (
            .clk        (clk),
            .rst        (rst),
            .i_load     (seed_load),
            .i_load_val (lane_seed(seed, 32'(i))),
            .i_adv      (in_valid),
            .o_state    (w_lfsr[i])
        );

        assign w_hit[i] = cfg_en & lane_mask[i] & in_valid & (w_lfsr[i] < w_thr[i]);
        assign w_flip[i*DW +: DW] = w_hit[i] ? ({{(DW-1){1'b0}}, 1'b1} << w_lfsr[i][BW-1:0])
                                             : {DW{1'b0}};

`ifdef BER_INJ_BURST_EN
        // state | meaning
        // GOOD  | background error rate, threshold cfg_thresh
        // BURST | clustered errors for cfg_burst_len valid beats, threshold cfg_burst_thresh
        lane_st_t    r_st;
        lane_st_t    w_st_nxt;
        logic [7:0]  r_bcnt;
        logic [7:0]  w_bcnt_nxt;
        prob_t       w_lane_thr;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_st   <= ST_GOOD;
                r_bcnt <= 8'd0;
            end else begin
                r_st   <= w_st_nxt;
                r_bcnt <= w_bcnt_nxt;
            end
        end

        always_comb begin
            w_st_nxt   = r_st;
            w_bcnt_nxt = r_bcnt;
            if (!cfg_en || !lane_mask[i]) begin
                w_st_nxt   = ST_GOOD;
                w_bcnt_nxt = 8'd0;
            end else if (in_valid) begin
                case (r_st)
                    ST_GOOD: begin
                        if (w_hit[i] && (cfg_burst_len != 8'd0)) begin
                            w_st_nxt   = ST_BURST;
                            w_bcnt_nxt = cfg_burst_len;
                        end
                    end
                    ST_BURST: begin
                        if (r_bcnt <= 8'd1) begin
                            w_st_nxt   = ST_GOOD;
                            w_bcnt_nxt = 8'd0;
                        end else begin
                            w_bcnt_nxt = r_bcnt - 8'd1;
                        end
                    end
                    default: begin
                        w_st_nxt   = ST_GOOD;
                        w_bcnt_nxt = 8'd0;
                    end
                endcase
            end
        end

        always_comb begin
            w_lane_thr = (r_st == ST_BURST) ? cfg_burst_thresh : cfg_thresh;
        end

        assign w_thr[i] = w_lane_thr;
`else
        assign w_thr[i] = cfg_thresh;
`endif
    end

`ifndef BER_INJ_BURST_EN
    logic w_unused_burst;
    assign w_unused_burst = ^{cfg_burst_thresh, cfg_burst_len};
`endif

    always_comb begin
        w_pop = '0;
        for (int j = 0; j < LANES; j++) begin
            w_pop = w_pop + {{CNT_W{1'b0}}, w_hit[j]};
        end
    end

    // One extra bit catches the carry out for saturation.
    assign w_sum = {1'b0, r_cnt} + w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_flag  <= '0;
            r_cnt   <= '0;
        end else begin
            r_valid <= in_valid;
            r_flag  <= w_hit;
            if (in_valid) begin
                r_data <= in_data ^ w_flip;
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_sum[CNT_W]) begin
                r_cnt <= '1;
            end else begin
                r_cnt <= w_sum[CNT_W-1:0];
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign err_flag  = r_flag;
    assign err_cnt   = r_cnt;

endmodule

// File: tb/tb_ber_channel_mc.sv
// Scoreboard bench for ber_channel_mc: random beats scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ber_channel_mc;

    localparam int          LANES = 4;
    localparam int          DW    = 16;
    localparam int          W     = LANES * DW;
    localparam logic [31:0] DSEED = 32'hACE1_2468;
`ifdef BER_INJ_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_en = 1'b0;
    logic [31:0]      cfg_thresh = 32'h0;
    logic [31:0]      cfg_burst_thresh = 32'h0;
    logic [7:0]       cfg_burst_len = 8'd0;
    logic [LANES-1:0] lane_mask = '0;
    logic             seed_load = 1'b0;
    logic [31:0]      seed = 32'h0;
    logic             cnt_clr = 1'b0;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;

    logic             out_valid, out_valid4;
    logic [W-1:0]     out_data, out_data4;
    logic [LANES-1:0] err_flag, err_flag4;
    logic [31:0]      err_cnt;
    logic [3:0]       err_cnt4;

    always #5 clk = ~clk;

    ber_channel_mc #(.LANES(LANES), .DW(DW), .CNT_W(32), .DEFAULT_SEED(DSEED)) u_dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_thresh(cfg_thresh),
        .cfg_burst_thresh(cfg_burst_thresh), .cfg_burst_len(cfg_burst_len),
        .lane_mask(lane_mask), .seed_load(seed_load), .seed(seed), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .err_flag(err_flag), .err_cnt(err_cnt)
    );

    // Narrow-counter copy on identical inputs exercises saturation.
    ber_channel_mc #(.LANES(LANES), .DW(DW), .CNT_W(4), .DEFAULT_SEED(DSEED)) u_dut4 (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_thresh(cfg_thresh),
        .cfg_burst_thresh(cfg_burst_thresh), .cfg_burst_len(cfg_burst_len),
        .lane_mask(lane_mask), .seed_load(seed_load), .seed(seed), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid4), .out_data(out_data4),
        .err_flag(err_flag4), .err_cnt(err_cnt4)
    );

    typedef struct {
        logic [W-1:0]     data;
        logic [LANES-1:0] flag;
        logic [31:0]      cnt;
        logic [3:0]       cnt4;
        int               phase;
    } exp_t;

    exp_t             q_exp[$];
    logic [LANES-1:0] rec_a[$];
    logic [LANES-1:0] rec_b[$];
    int               idx_a = 0;
    int               idx_b = 0;
    int               n_tests = 0;
    int               n_fail = 0;

    logic [31:0] m_lfsr [LANES];
    bit          m_burst[LANES];
    int          m_bc   [LANES];
    longint      m_cnt;
    int          m_cnt4;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic logic [31:0] seed_of(input logic [31:0] base, input int l);
        logic [31:0] v;
        v = base ^ (32'(l) * 32'h9E37_79B9);
        return (v == 32'h0) ? 32'h1 : v;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_reset();
        for (int l = 0; l < LANES; l++) begin
            m_lfsr[l]  = seed_of(DSEED, l);
            m_burst[l] = 1'b0;
            m_bc[l]    = 0;
        end
        m_cnt  = 0;
        m_cnt4 = 0;
    endtask

    // Predict one cycle, queue the expectation, then apply it to the DUT for one clock.
    task automatic step(input bit v, input logic [W-1:0] d, input bit sl,
                        input logic [31:0] sd, input bit clr, input int ph);
        exp_t             e;
        logic [LANES-1:0] h;
        logic [31:0]      thr;
        int               pop;
        e.data = d;
        h      = '0;
        pop    = 0;
        for (int l = 0; l < LANES; l++) begin
            thr = m_burst[l] ? cfg_burst_thresh : cfg_thresh;
            if (cfg_en && lane_mask[l] && v && (m_lfsr[l] < thr)) begin
                h[l] = 1'b1;
                pop++;
                e.data[l*DW + int'(m_lfsr[l] % DW)] ^= 1'b1;
            end
        end
        e.flag = h;
        if (clr) begin
            m_cnt  = 0;
            m_cnt4 = 0;
        end else begin
            m_cnt  = (m_cnt + pop > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + pop;
            m_cnt4 = (m_cnt4 + pop > 15) ? 15 : m_cnt4 + pop;
        end
        e.cnt   = m_cnt[31:0];
        e.cnt4  = 4'(m_cnt4);
        e.phase = ph;
        for (int l = 0; l < LANES; l++) begin
            if (!cfg_en || !lane_mask[l]) begin
                m_burst[l] = 1'b0;
                m_bc[l]    = 0;
            end else if (v && BURST_EN) begin
                if (m_burst[l]) begin
                    if (m_bc[l] <= 1) begin
                        m_burst[l] = 1'b0;
                        m_bc[l]    = 0;
                    end else begin
                        m_bc[l] = m_bc[l] - 1;
                    end
                end else if (h[l] && cfg_burst_len != 8'd0) begin
                    m_burst[l] = 1'b1;
                    m_bc[l]    = int'(cfg_burst_len);
                end
            end
            if (sl)     m_lfsr[l] = seed_of(sd, l);
            else if (v) m_lfsr[l] = lfsr_next(m_lfsr[l]);
        end
        in_valid  = v;
        in_data   = d;
        seed_load = sl;
        seed      = sd;
        cnt_clr   = clr;
        if (v) q_exp.push_back(e);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst       = 1'b1;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        cnt_clr   = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_data"},  64'(out_data),  64'd0);
        chk({nm, "_flag"},  64'(err_flag),  64'd0);
        chk({nm, "_cnt"},   64'(err_cnt),   64'd0);
        chk({nm, "_cnt4"},  64'(err_cnt4),  64'd0);
        model_reset();
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (out_valid) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: output beat with empty queue at %0t", $time);
            end else begin
                mon_e = q_exp.pop_front();
                chk("out_data",   64'(out_data),   64'(mon_e.data));
                chk("err_flag",   64'(err_flag),   64'(mon_e.flag));
                chk("err_cnt",    64'(err_cnt),    64'(mon_e.cnt));
                chk("out_valid4", 64'(out_valid4), 64'd1);
                chk("out_data4",  64'(out_data4),  64'(mon_e.data));
                chk("err_cnt4",   64'(err_cnt4),   64'(mon_e.cnt4));
                if (mon_e.phase == 1) rec_a.push_back(err_flag);
                if (mon_e.phase == 3) rec_b.push_back(err_flag);
                if (mon_e.phase == 2) begin
                    if (idx_a < rec_a.size()) chk("repro_seed", 64'(err_flag), 64'(rec_a[idx_a]));
                    else chk("repro_seed_len", 64'(idx_a), 64'(rec_a.size()));
                    idx_a++;
                end
                if (mon_e.phase == 4) begin
                    if (idx_b < rec_b.size()) chk("repro_reset", 64'(err_flag), 64'(rec_b[idx_b]));
                    else chk("repro_reset_len", 64'(idx_b), 64'(rec_b.size()));
                    idx_b++;
                end
            end
        end else if (!rst) begin
            chk("err_flag_idle", 64'(err_flag), 64'd0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] d_c [300];
    bit           v_c [300];
    int           nv;
    bit           v;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Pass-through: injection disabled regardless of threshold and mask.
        cfg_en     = 1'b0;
        cfg_thresh = 32'hFFFF_FFFF;
        lane_mask  = '1;
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(99) < 80, rnd_data(), 1'b0, 32'h0, 1'b0, 0);
        end
        chk("cnt_passthru", 64'(err_cnt), 64'd0);

        // Certain hit on lanes 0 and 2 only.
        cfg_en    = 1'b1;
        lane_mask = 4'b0101;
        step(1'b0, '0, 1'b0, 32'h0, 1'b1, 0);
        nv = 0;
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(99) < 85);
            if (v) nv++;
            step(v, rnd_data(), 1'b0, 32'h0, 1'b0, 0);
        end
        chk("cnt_mask0101", 64'(err_cnt), 64'(2 * nv));
        chk("cnt4_sat", 64'(err_cnt4), 64'((2 * nv > 15) ? 15 : 2 * nv));

        // Clear colliding with four simultaneous hits.
        lane_mask = 4'hF;
        step(1'b1, rnd_data(), 1'b0, 32'h0, 1'b1, 0);
        chk("clr_wins", 64'(err_cnt), 64'd0);
        chk("clr_wins4", 64'(err_cnt4), 64'd0);
        for (int i = 0; i < 5; i++) step(1'b1, rnd_data(), 1'b0, 32'h0, 1'b0, 0);
        chk("cnt4_sat15", 64'(err_cnt4), 64'd15);

        // Randomized configuration, seed loads (including on valid beats) and clears.
        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 0) begin
                cfg_en           = ($urandom_range(3) != 0);
                lane_mask        = 4'($urandom);
                cfg_burst_len    = 8'($urandom_range(4));
                cfg_burst_thresh = $urandom;
                case ($urandom_range(3))
                    0: cfg_thresh = 32'h0;
                    1: cfg_thresh = 32'hFFFF_FFFF;
                    2: cfg_thresh = 32'h1000_0000;
                    default: cfg_thresh = $urandom;
                endcase
            end
            step($urandom_range(99) < 75, rnd_data(), $urandom_range(99) < 3, $urandom,
                 $urandom_range(99) < 2, 0);
        end

        // Statistical rate and seed reproducibility.
        cfg_en        = 1'b1;
        lane_mask     = 4'hF;
        cfg_thresh    = 32'h0100_0000;
        cfg_burst_len = 8'd0;
        step(1'b0, '0, 1'b1, 32'h1357_9BDF, 1'b1, 0);
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, rnd_data(), 1'b0, 32'h0, 1'b0, (i < 2048) ? 1 : 0);
        end
        n_tests++;
        if (err_cnt < 32'd870 || err_cnt > 32'd1178) begin
            n_fail++;
            $display("FAIL ber_rate: got %0d want 870..1178", err_cnt);
        end
        step(1'b0, '0, 1'b1, 32'h1357_9BDF, 1'b0, 0);
        for (int i = 0; i < 2048; i++) begin
            step(1'b1, rnd_data(), 1'b0, 32'h0, 1'b0, 2);
        end

`ifdef BER_INJ_BURST_EN
        // Rare background hits each followed by an 8-beat certain-error burst.
        cfg_thresh       = 32'h0080_0000;
        cfg_burst_thresh = 32'hFFFF_FFFF;
        cfg_burst_len    = 8'd8;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99) < 90, rnd_data(), 1'b0, 32'h0, 1'b0, 0);
        end
`endif

        // Fresh-reset run, then a mid-run reset replaying the same stimulus.
        cfg_thresh       = 32'h1000_0000;
        cfg_burst_thresh = 32'hFFFF_FFFF;
        cfg_burst_len    = 8'd8;
        lane_mask        = 4'hF;
        do_reset("reset_fresh");
        for (int i = 0; i < 300; i++) begin
            d_c[i] = rnd_data();
            v_c[i] = ($urandom_range(99) < 90);
            step(v_c[i], d_c[i], 1'b0, 32'h0, 1'b0, 3);
        end
        for (int i = 0; i < 37; i++) step(1'b1, rnd_data(), 1'b0, 32'h0, 1'b0, 0);
        do_reset("reset_mid");
        for (int i = 0; i < 300; i++) begin
            step(v_c[i], d_c[i], 1'b0, 32'h0, 1'b0, 4);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 64'(q_exp.size()), 64'd0);
        chk("repro_seed_count", 64'(idx_a), 64'(rec_a.size()));
        chk("repro_reset_count", 64'(idx_b), 64'(rec_b.size()));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ber_channel_mc.md
# ber_channel_mc

Multi-lane, parallel-word bit-error injector placed between the SerDes TX datapath and RX deserializer models in the PHY test harness. It replaces single-bit real-valued random flipping with deterministic per-lane LFSR draws compared against an integer probability threshold, so a run with a given seed is fully reproducible. Optional burst mode models clustered errors. Per-lane error flags and an aggregate error counter feed the UVM scoreboard and coverage.

## Interface
- LANES, 4, number of independent lanes
- DW, 16, bits per lane per beat; power of two, ≥2
- CNT_W, 32, width of aggregate error counter
- DEFAULT_SEED, 32'hACE1_2468, LFSR base seed applied at reset
- clk  input  1  datapath clock
- rst  input  1  synchronous, active-high reset
- cfg_en  input  1  0 = pure pass-through, 1 = injection active
- cfg_thresh  input  32  per-beat, per-lane error probability = cfg_thresh / 2^32
- cfg_burst_thresh  input  32  per-beat error probability while in BURST
- cfg_burst_len  input  8  BURST duration in valid beats; 0 disables bursts
- lane_mask  input  LANES  1 = lane eligible for injection
- seed_load  input  1  reload all lane LFSRs from seed
- seed  input  32  seed value used with seed_load
- cnt_clr  input  1  clear err_cnt
- in_valid  input  1  input beat valid
- in_data  input  LANES*DW  lane i at [i*DW +: DW]
- out_valid  output  1  output beat valid
- out_data  output  LANES*DW  possibly corrupted data
- err_flag  output  LANES  1 = lane i corrupted in current output beat
- err_cnt  output  CNT_W  saturating total of corrupted lane-beats

## Operation
- Per lane: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (taps 32'h8020_0003); advances once per in_valid beat regardless of cfg_en/lane_mask.
- Lane seed = base ^ (i * 32'h9E37_79B9); if result is 0, use 32'h1. Base = DEFAULT_SEED at reset, seed at seed_load.
- seed_load beats: LFSRs load, do not advance; the beat still passes through with injection decision from pre-load state.
- Hit for lane i: cfg_en & lane_mask[i] & in_valid & (lfsr_i < active threshold). Threshold 0 → never hits.
- On hit: flip exactly one bit, position = lfsr_i[$clog2(DW)-1:0].
- Per-lane FSM: GOOD (threshold = cfg_thresh), BURST (threshold = cfg_burst_thresh).
  - GOOD → BURST on a hit when cfg_burst_len ≠ 0; burst counter loads cfg_burst_len.
  - BURST: counter decrements each valid beat; on a valid beat with counter == 1 → GOOD.
  - cfg_en = 0 or lane_mask[i] = 0 forces lane FSM to GOOD.
- err_cnt += popcount(hits) each beat, saturates at all-ones; cnt_clr wins over a same-cycle increment (result 0).

## Timing
- Fixed 1-cycle latency: out_valid/out_data/err_flag registered from same-cycle inputs.
- out_data holds last value when in_valid = 0; err_flag is 0 on non-valid cycles.
- Config inputs sampled every cycle; changes take effect on the next valid beat.
- Reset (any cycle, including mid-burst): out_valid 0, out_data 0, err_flag 0, err_cnt 0, all FSMs GOOD, burst counters 0, LFSRs at DEFAULT_SEED-derived values.

## Configuration
- BER_INJ_BURST_EN defined: BURST state and burst counters present as above.
- Undefined: FSM and counters not built; lanes always use cfg_thresh; cfg_burst_thresh/cfg_burst_len ports remain but are ignored.

## Structure
- Package ber_pkg: polynomial constant, lane seed multiplier, lane state enum (GOOD, BURST), 32-bit probability typedef.
- Sub-module ber_lfsr32: one LFSR with load/advance, instantiated LANES times.

## Test plan
- cfg_en=0, 1000 random beats → out_data == in_data delayed 1 cycle, err_cnt 0.
- cfg_thresh=32'hFFFF_FFFF, lane_mask=4'b0101 → lanes 0,2 each exactly one bit flipped every beat, lanes 1,3 clean, err_cnt +2 per beat.
- cfg_thresh=32'h0100_0000 (1/256), 2^16 beats, 4 lanes → err_cnt within 1024 ± 15%; rerun after seed_load with same seed → identical err_flag sequence.
- BER_INJ_BURST_EN, cfg_burst_len=8, cfg_burst_thresh=all-ones, rare cfg_thresh → each GOOD hit followed by exactly 8 consecutive corrupted valid beats on that lane.
- err_cnt preloaded near all-ones with CNT_W=4 → saturates at 15; cnt_clr with simultaneous hits → 0.
- Assert rst mid-burst → next cycle all outputs 0, subsequent sequence matches fresh-reset run.
